// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end controller and the ALU opcode decode.
package alu_pkg;

   localparam int unsigned FUNC_W_DEFAULT = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_SHOW  = 2'd3
   } state_t;

endpackage

// File: rtl/pb_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a 1-cycle press pulse.
module pb_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pb,
   output logic o_press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    r_sync;
   logic          r_level;
   logic [CW-1:0] r_cnt;
   logic          w_diff;
   logic          w_flip;

   assign w_diff = r_sync[1] ^ r_level;
   assign w_flip = w_diff && (r_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync  <= 2'b00;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync <= {r_sync[0], i_pb};
         if (w_flip) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
         end else if (w_diff) begin
            r_cnt <= r_cnt + CW'(1);
         end else begin
            r_cnt <= '0;
         end
      end
   end

   // Pulse in the cycle the level is about to rise; releases never pulse.
   assign o_press = w_flip & r_sync[1];

endmodule

// File: rtl/alu_op_sequencer.sv
// Button/switch front end for the 4-bit ALU: operand capture, start/done handshake with
// timeout, and result/flag display.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned FUNC_W          = FUNC_W_DEFAULT,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned TIMEOUT_CYCLES  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        pb,
   input  logic [WIDTH-1:0]  sw,
   input  logic              alu_done,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_ovf,
   output logic [WIDTH-1:0]  op_a,
   output logic [WIDTH-1:0]  op_b,
   output logic [FUNC_W-1:0] func,
   output logic              alu_start,
   output logic [WIDTH-1:0]  led,
   output logic              ovf_flag,
   output logic              busy,
   output logic              err
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0] w_press;

   for (genvar g = 0; g < 3; g++) begin : g_pb
      pb_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_pb_debounce (
         .clk    (clk),
         .rst    (rst),
         .i_pb   (pb[g]),
         .o_press(w_press[g])
      );
   end

   state_t            r_state, w_state_d;
   logic [WIDTH-1:0]  r_op_a, w_op_a_d;
   logic [WIDTH-1:0]  r_op_b, w_op_b_d;
   logic [FUNC_W-1:0] r_func, w_func_d;
   logic [WIDTH-1:0]  r_led, w_led_d;
   logic              r_ovf, w_ovf_d;
   logic              r_err, w_err_d;
   logic [TW-1:0]     r_timer, w_timer_d;
   logic              w_load;

   assign w_load = w_press[0] | w_press[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op_a  <= '0;
         r_op_b  <= '0;
         r_func  <= '0;
         r_led   <= '0;
         r_ovf   <= 1'b0;
         r_err   <= 1'b0;
         r_timer <= '0;
      end else begin
         r_state <= w_state_d;
         r_op_a  <= w_op_a_d;
         r_op_b  <= w_op_b_d;
         r_func  <= w_func_d;
         r_led   <= w_led_d;
         r_ovf   <= w_ovf_d;
         r_err   <= w_err_d;
         r_timer <= w_timer_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_op_a_d  = r_op_a;
      w_op_b_d  = r_op_b;
      w_func_d  = r_func;
      w_led_d   = r_led;
      w_ovf_d   = r_ovf;
      w_err_d   = r_err;
      w_timer_d = r_timer;
      unique case (r_state)
         S_IDLE, S_SHOW: begin
            // Loads land on the same edge as an execute, so ISSUE sees the new operand.
            if (w_press[0]) w_op_a_d = sw;
            if (w_press[1]) w_op_b_d = sw;
            if (w_load)     w_led_d  = sw;
            if (w_press[2]) begin
               w_func_d  = sw[FUNC_W-1:0];
               w_state_d = S_ISSUE;
            end else if (w_load) begin
               w_ovf_d   = 1'b0;
               w_err_d   = 1'b0;
               w_state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            w_timer_d = '0;
            w_state_d = S_WAIT;
         end
         S_WAIT: begin
            if (alu_done) begin
               w_led_d   = alu_result;
               w_ovf_d   = alu_ovf;
               w_err_d   = 1'b0;
               w_state_d = S_SHOW;
            end else if (r_timer == TIMER_LAST) begin
               w_led_d   = '1;
               w_ovf_d   = 1'b0;
               w_err_d   = 1'b1;
               w_state_d = S_SHOW;
            end else begin
               w_timer_d = r_timer + TW'(1);
            end
         end
         default: w_state_d = S_IDLE;
      endcase
   end

   assign op_a      = r_op_a;
   assign op_b      = r_op_b;
   assign func      = r_func;
   assign led       = r_led;
   assign ovf_flag  = r_ovf;
   assign err       = r_err;
   assign alu_start = (r_state == S_ISSUE);
   assign busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a 3-cycle-latency behavioural ALU.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] pb;
   logic [3:0] sw;
   logic       alu_done;
   logic [3:0] alu_result;
   logic       alu_ovf;
   logic [3:0] op_a;
   logic [3:0] op_b;
   logic [2:0] func;
   logic       alu_start;
   logic [3:0] led;
   logic       ovf_flag;
   logic       busy;
   logic       err;

   alu_op_sequencer #(
      .WIDTH          (4),
      .FUNC_W         (3),
      .DEBOUNCE_CYCLES(8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pb        (pb),
      .sw        (sw),
      .alu_done  (alu_done),
      .alu_result(alu_result),
      .alu_ovf   (alu_ovf),
      .op_a      (op_a),
      .op_b      (op_b),
      .func      (func),
      .alu_start (alu_start),
      .led       (led),
      .ovf_flag  (ovf_flag),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   // ALU model: done 3 cycles after start; not reset, so a late done can follow rst.
   logic       model_en  = 1'b1;
   logic       model_ovf = 1'b0;
   logic [2:0] r_pipe    = 3'b000;
   always @(posedge clk) r_pipe <= {r_pipe[1:0], alu_start & model_en};
   assign alu_done = r_pipe[2];
   assign alu_ovf  = model_ovf;
   always_comb begin
      alu_result = op_a ^ op_b;
      if (func == 3'd0) alu_result = op_a + op_b;
      else if (func == 3'd1) alu_result = op_a - op_b;
   end

   int n_start = 0;
   int n_busy  = 0;
   always @(posedge clk) begin
      if (alu_start) n_start <= n_start + 1;
      if (busy)      n_busy  <= n_busy + 1;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int idx);
      pb[idx] = 1'b1;
      tick(20);
      pb[idx] = 1'b0;
      tick(12);
   endtask

   int  s_start;
   int  s_busy;
   bit  seen;

   initial begin
      rst = 1'b1;
      pb  = 3'b000;
      sw  = 4'd0;
      tick(3);
      check("rst_op_a", op_a, 0);
      check("rst_led", led, 0);
      check("rst_busy", busy, 0);
      check("rst_start", alu_start, 0);
      rst = 1'b0;
      tick(2);

      // Load and execute: 5 + 4.
      sw = 4'd5; press(0);
      check("load_a", op_a, 5);
      check("load_a_led", led, 5);
      sw = 4'd4; press(1);
      check("load_b", op_b, 4);
      s_start = n_start; s_busy = n_busy;
      model_ovf = 1'b0;
      sw = 4'd0; press(2);
      check("add_starts", n_start - s_start, 1);
      check("add_busy_cycles", n_busy - s_busy, 4);
      check("add_led", led, 9);
      check("add_ovf", ovf_flag, 0);
      check("add_err", err, 0);

      // Glitch shorter than the debounce window is ignored.
      sw = 4'd7;
      pb[0] = 1'b1; tick(5); pb[0] = 1'b0; tick(15);
      check("glitch_op_a", op_a, 5);
      // Press accepted exactly 10 cycles after the raw rise.
      pb[0] = 1'b1;
      tick(9);
      check("latency_early", op_a, 5);
      tick(1);
      check("latency_load", op_a, 7);
      check("show_exit_err", err, 0);
      tick(10); pb[0] = 1'b0; tick(12);

      // Overflow then a chained SUB from SHOW.
      sw = 4'd1; press(1);
      check("load_b1", op_b, 1);
      model_ovf = 1'b1;
      sw = 4'd0; press(2);
      check("ovf_led", led, 8);
      check("ovf_flag", ovf_flag, 1);
      s_start = n_start;
      model_ovf = 1'b0;
      sw = 4'd1; press(2);
      check("chain_starts", n_start - s_start, 1);
      check("chain_func", func, 1);
      check("chain_led", led, 6);
      check("chain_ovf", ovf_flag, 0);

      // Timeout, with a second execute press landing inside WAIT.
      model_en = 1'b0;
      s_start = n_start; s_busy = n_busy;
      sw = 4'd2;
      pb[2] = 1'b1; tick(8);
      pb[2] = 1'b0; tick(8);
      pb[2] = 1'b1; tick(20);
      pb[2] = 1'b0; tick(12);
      check("drop_starts", n_start - s_start, 1);
      check("timeout_busy", n_busy - s_busy, 17);
      check("timeout_led", led, 4'hF);
      check("timeout_err", err, 1);
      check("timeout_ovf", ovf_flag, 0);
      sw = 4'd3; press(0);
      check("clear_err", err, 0);
      check("clear_led", led, 3);
      check("clear_busy", busy, 0);

      // Simultaneous load-A and execute in IDLE: ISSUE uses the new operand.
      model_en = 1'b1;
      s_start = n_start;
      sw = 4'd8;
      pb[0] = 1'b1; pb[2] = 1'b1; tick(20);
      pb[0] = 1'b0; pb[2] = 1'b0; tick(12);
      check("simul_op_a", op_a, 8);
      check("simul_func", func, 0);
      check("simul_starts", n_start - s_start, 1);
      check("simul_led", led, 9);

      // Reset two cycles into the handshake; the late done must be ignored.
      sw = 4'd0;
      seen = 1'b0;
      pb[2] = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick(1);
         if (alu_start) seen = 1'b1;
      end
      check("mid_start_seen", seen, 1);
      tick(2);
      rst = 1'b1; pb[2] = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_start", alu_start, 0);
      check("mid_rst_led", led, 0);
      check("mid_rst_op_a", op_a, 0);
      check("mid_rst_op_b", op_b, 0);
      check("mid_rst_func", func, 0);
      check("mid_rst_err", err, 0);
      #1 rst = 1'b0;
      tick(4);
      check("late_done_led", led, 0);
      check("late_done_ovf", ovf_flag, 0);
      check("late_done_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
